muxn_rr_stage: RTL and testbench
================================

Name: muxn_rr_stage

Overview:
- Parametrised N-input, WIDTH-bit selector with a one-entry registered output stage.
- Supports valid/ready handshakes on every input and on the output.
- Two modes: fixed selection by ctrl, or round-robin arbitration across inputs.
- Sits in the MIPS datapath/interconnect wherever several producers feed one registered consumer, e.g. writeback source select or memory-port sharing.

Parameters:
- WIDTH, 32, data width per channel.
- N_IN, 4, number of input channels (2..16, need not be a power of 2).
- SEL_W, $clog2(N_IN), localparam, width of ctrl and out_src.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = fixed select, 1 = round-robin.
- ctrl  in  SEL_W  channel index used in fixed mode.
- in_data  in  N_IN*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N_IN  per-channel valid.
- in_ready  out  N_IN  per-channel ready (combinational).
- out_data  out  WIDTH  registered output word.
- out_src  out  SEL_W  index of the channel that supplied out_data.
- out_valid  out  1  output holds a word.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset: out_valid=0, out_data=0, out_src=0, rr_ptr=N_IN-1, so the first round-robin search starts at channel 0. A held word is discarded on reset.
- load_en = !out_valid || out_ready. The stage accepts a new word when empty, or when the held word is drained in the same cycle. This gives full throughput: 1 word/cycle, latency 1 cycle.
- Fixed mode:
  - grant = ctrl if in_valid[ctrl]; otherwise no grant.
  - If ctrl >= N_IN, there is no grant.
- Round-robin mode:
  - grant = first i with in_valid[i], searching rr_ptr+1, rr_ptr+2, ... and wrapping modulo N_IN.
  - rr_ptr <= grant only on a transfer.
- in_ready[i] = load_en && (i == grant). At most one bit is high. in_ready is 0 for all channels when there is no grant.
- Transfer (granted channel's valid && in_ready): next cycle out_data = that channel's word, out_src = grant, out_valid = 1.
- Output drained with no new transfer: out_valid <= 0. out_data and out_src hold their values.
- Output stall (out_valid && !out_ready): out_data and out_src stay stable; all in_ready = 0.
- mode and ctrl are sampled combinationally each cycle. A change affects only the next arbitration, never a held word. rr_ptr is kept across fixed-mode periods.
- in_valid may drop without a transfer; no protocol error is flagged.

Optional Feature:
- Macro: MUXN_LOCK_EN.
- Defined:
  - Adds port in_last (in, N_IN), marking the final beat of a packet.
  - In round-robin mode, after a transfer with in_last[grant]=0, arbitration is locked to that channel. Other channels get in_ready=0 until a transfer with in_last=1 completes.
  - Fixed mode ignores the lock.
  - Reset clears the lock.
  - Adds output out_last (registered alongside out_data).
- Undefined: no in_last/out_last ports; every beat is arbitrated independently.

Decomposition:
- Package muxn_pkg:
  - mode constants MODE_FIXED=1'b0, MODE_RR=1'b1.
  - function rr_next(ptr, valid) returning the index and a found flag, shared with other arbiters.
- One natural sub-module: rr_pick. It is a combinational rotate-priority encoder (inputs valid vector and ptr; outputs grant and found), instantiated once.

Test Plan:
- Fixed, ctrl=2, in_valid=4'b1111, ch2=32'hCAFE0002, out_ready=1 -> in_ready=4'b0100; next cycle out_data=CAFE0002, out_src=2, out_valid=1.
- RR, all valid, out_ready=1 for 6 cycles -> out_src sequence 0,1,2,3,0,1 on consecutive cycles, one word per cycle.
- RR, in_valid=4'b1010, rr_ptr=1 -> grant 3, then 1, then 3.
- Output stall: out_valid=1, out_ready=0 for 3 cycles -> out_data stable, in_ready=0; drain cycle with new valid -> back-to-back transfer, no bubble.
- rst asserted while out_valid=1 and ch1 valid -> next cycle out_valid=0, out_data=0, rr_ptr=3; first RR grant afterwards is the lowest valid channel.
- MUXN_LOCK_EN: ch0 sends beats last=0,0,1 while ch1 is valid -> out_src 0,0,0, then 1.

Source files
------------

// File: rtl/muxn_pkg.sv
// Shared definitions for the N-input selector stage: mode encoding and the
// rotate-priority search used by this and other arbiters.
package muxn_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int RR_MAX = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_res_t;

  // First set bit of valid[n-1:0] searching ptr+1, ptr+2, ... modulo n.
  // Walking the offsets from far to near lets the nearest hit win last.
  function automatic rr_res_t rr_next(input logic [3:0] ptr,
                                      input logic [RR_MAX-1:0] valid,
                                      input int n);
    rr_res_t r;
    int      c;
    r = '0;
    for (int k = RR_MAX; k >= 1; k--) begin
      if (k <= n) begin
        c = (int'(ptr) + k) % n;
        if (valid[c]) begin
          r.found = 1'b1;
          r.idx   = c[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: lowest-distance valid channel after ptr.
module rr_pick
  import muxn_pkg::*;
#(
  parameter int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  valid,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             found
);

  rr_res_t res;

  always_comb begin
    res   = rr_next(4'(ptr), RR_MAX'(valid), N_IN);
    grant = res.idx[SEL_W-1:0];
    found = res.found;
  end

endmodule

// File: rtl/muxn_rr_stage.sv
// N-input selector (fixed or round-robin) feeding a one-entry registered output.
// Optional packet lock on round-robin grants: define MUXN_LOCK_EN.
module muxn_rr_stage
  import muxn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      ctrl,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
`ifdef MUXN_LOCK_EN
  input  logic [N_IN-1:0]       in_last,
  output logic                  out_last,
`endif
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_src,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int SEL_N = 1 << SEL_W;

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_grant, grant;
  logic             rr_found, has_grant;
  logic [SEL_N-1:0] valid_ext;
  logic             load_en, xfer;

  rr_pick #(.N_IN(N_IN)) u_pick (
    .valid (in_valid),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .found (rr_found)
  );

`ifdef MUXN_LOCK_EN
  logic             locked;
  logic [SEL_W-1:0] lock_ch;
`endif

  always_comb begin
    // Zero-extended so ctrl values >= N_IN simply find no valid.
    valid_ext               = '0;
    valid_ext[N_IN-1:0]     = in_valid;
    load_en                 = !out_valid || out_ready;
    if (mode == MODE_FIXED) begin
      grant     = ctrl;
      has_grant = valid_ext[ctrl];
`ifdef MUXN_LOCK_EN
    end else if (locked) begin
      grant     = lock_ch;
      has_grant = valid_ext[lock_ch];
`endif
    end else begin
      grant     = rr_grant;
      has_grant = rr_found;
    end
    xfer     = load_en && has_grant;
    in_ready = xfer ? (N_IN'(1) << grant) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= SEL_W'(N_IN - 1);
`ifdef MUXN_LOCK_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant*WIDTH +: WIDTH];
      out_src   <= grant;
`ifdef MUXN_LOCK_EN
      out_last  <= in_last[grant];
`endif
      if (mode == MODE_RR) begin
        rr_ptr  <= grant;
`ifdef MUXN_LOCK_EN
        locked  <= !in_last[grant];
        lock_ch <= grant;
`endif
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muxn_rr_stage.sv
// Directed self-checking bench for muxn_rr_stage (N_IN=4, WIDTH=32).
module tb_muxn_rr_stage;

  localparam int WIDTH = 32;
  localparam int N_IN  = 4;
  localparam int SEL_W = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mode;
  logic [SEL_W-1:0]      ctrl;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_src;
  logic                  out_valid;
  logic                  out_ready;
`ifdef MUXN_LOCK_EN
  logic [N_IN-1:0]       in_last;
  logic                  out_last;
`endif

  int checks = 0;
  int errors = 0;

  muxn_rr_stage #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .ctrl      (ctrl),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef MUXN_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rr_seq [6] = '{0, 1, 2, 3, 0, 1};
  int alt_seq[3] = '{3, 1, 3};

  initial begin
    rst = 1'b1; mode = 1'b0; ctrl = '0; in_valid = '0; out_ready = 1'b1;
`ifdef MUXN_LOCK_EN
    in_last = '1;
`endif
    for (int i = 0; i < N_IN; i++) in_data[i*WIDTH +: WIDTH] = 32'hCAFE0000 + i;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_src",   64'(out_src),   64'd0);
    chk("rst_ready", 64'(in_ready),  64'd0);

    // fixed select
    mode = 1'b0; ctrl = 2'd2; in_valid = 4'b1111;
    #1 chk("fix_ready", 64'(in_ready), 64'b0100);
    tick();
    chk("fix_data",  64'(out_data),  64'hCAFE0002);
    chk("fix_src",   64'(out_src),   64'd2);
    chk("fix_valid", 64'(out_valid), 64'd1);

    // round robin, all valid; pointer still at 3 from reset
    mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_ready", 64'(in_ready), 64'(4'b0001 << rr_seq[k]));
      tick();
      chk("rr_src",   64'(out_src),   64'(rr_seq[k]));
      chk("rr_valid", 64'(out_valid), 64'd1);
    end

    // sparse valid, pointer at 1
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("alt_src", 64'(out_src), 64'(alt_seq[k]));
    end

    // stall holds word, no ready
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_ready", 64'(in_ready), 64'd0);
      tick();
      chk("stall_data",  64'(out_data),  64'hCAFE0003);
      chk("stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1 chk("drain_ready", 64'(in_ready), 64'b0001);
    tick();
    chk("drain_src",   64'(out_src),   64'd0);
    chk("drain_valid", 64'(out_valid), 64'd1);
    in_valid = '0;
    tick();
    chk("empty_valid", 64'(out_valid), 64'd0);
    chk("empty_hold",  64'(out_data),  64'hCAFE0000);

    // reset while holding a word
    in_valid = 4'b0010; out_ready = 1'b0;
    tick();
    chk("pre_rst_src", 64'(out_src), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    chk("rst2_valid", 64'(out_valid), 64'd0);
    chk("rst2_data",  64'(out_data),  64'd0);
    in_valid = 4'b1010;
    #1 chk("rst2_ready", 64'(in_ready), 64'b0010);
    tick();
    chk("rst2_src", 64'(out_src), 64'd1);

    // fixed mode on an idle channel: no grant, output drains
    mode = 1'b0; ctrl = 2'd0;
    #1 chk("fix_idle_ready", 64'(in_ready), 64'd0);
    tick();
    chk("fix_idle_valid", 64'(out_valid), 64'd0);

`ifdef MUXN_LOCK_EN
    // ch0 packet of three beats while ch1 competes; rr_ptr is 1
    mode = 1'b1; in_valid = 4'b0011; in_last = 4'b0010;
    tick();
    chk("lock_src0", 64'(out_src), 64'd0);
    #1 chk("lock_ready", 64'(in_ready), 64'b0001);
    tick();
    chk("lock_src1", 64'(out_src), 64'd0);
    in_last = 4'b0011;
    tick();
    chk("lock_src2", 64'(out_src), 64'd0);
    chk("lock_last", 64'(out_last), 64'd1);
    tick();
    chk("lock_src3", 64'(out_src), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
